// File: rtl/quadrature_demodulator_pkg.sv
// Shared definitions for the quadrature demodulator: frequency codes, FSM states
// and I/Q reference helpers.
package quadrature_demodulator_pkg;

  localparam logic [1:0] FREQ_8MHZ = 2'd0;
  localparam logic [1:0] FREQ_4MHZ = 2'd1;
  localparam logic [1:0] FREQ_2MHZ = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Terminal value of the sample divider (divide ratio minus one).
  function automatic logic [1:0] div_last(input logic [1:0] freq_code);
    logic [1:0] last;
    case (freq_code)
      FREQ_8MHZ: last = 2'd0;
      FREQ_4MHZ: last = 2'd1;
      default:   last = 2'd3;
    endcase
    return last;
  endfunction

  // Iref is -1 for phases 4-7.
  function automatic logic iref_neg(input logic [2:0] phase);
    return phase[2];
  endfunction

  // Qref is +1 for phases 2-5, -1 otherwise.
  function automatic logic qref_neg(input logic [2:0] phase);
    return ~(phase[2] ^ phase[1]);
  endfunction

endpackage

// File: rtl/quadrature_demodulator_channel.sv
// One demodulator arm: saturating signed accumulator with synchronous clear and
// a sticky clip flag.
module quadrature_demodulator_channel #(
  parameter int ADC_W = 12,
  parameter int ACC_W = 28
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    clr_i,
  input  logic                    en_i,
  input  logic                    sub_i,
  input  logic [ADC_W-1:0]        sample_i,
  output logic signed [ACC_W-1:0] acc_o,
  output logic                    clip_o
);

  localparam logic [ACC_W-1:0] MAX_POS = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] MIN_NEG = {1'b1, {(ACC_W-1){1'b0}}};

  logic [ACC_W:0]   samp_ext;
  logic [ACC_W:0]   acc_ext;
  logic [ACC_W:0]   sum;
  logic [ACC_W-1:0] acc_d, acc_q;
  logic             clip_d, clip_q;

  // One guard bit: the two top bits of the sum disagree exactly on overflow.
  always_comb begin
    samp_ext = {{(ACC_W+1-ADC_W){sample_i[ADC_W-1]}}, sample_i};
    acc_ext  = {acc_q[ACC_W-1], acc_q};
    sum      = sub_i ? (acc_ext - samp_ext) : (acc_ext + samp_ext);
    acc_d    = acc_q;
    clip_d   = clip_q;
    if (clr_i) begin
      acc_d  = {ACC_W{1'b0}};
      clip_d = 1'b0;
    end else if (en_i) begin
      if (sum[ACC_W] != sum[ACC_W-1]) begin
        acc_d  = sum[ACC_W] ? MIN_NEG : MAX_POS;
        clip_d = 1'b1;
      end else begin
        acc_d  = sum[ACC_W-1:0];
      end
    end else begin
      acc_d  = acc_q;
    end
  end

  // Accumulator state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc_q  <= {ACC_W{1'b0}};
      clip_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      clip_q <= clip_d;
    end
  end

  assign acc_o  = acc_q;
  assign clip_o = clip_q;

endmodule

// File: rtl/quadrature_demodulator.sv
// Quadrature demodulator: samples echo data inside the DEMOD_ON window, mixes it
// with square-wave I/Q references and hands one result per pulse to the host.
module quadrature_demodulator
  import quadrature_demodulator_pkg::*;
#(
  parameter int ADC_W = 12,
  parameter int ACC_W = 28,
  parameter int CNT_W = 16
) (
  input  logic                    coreClock,
  input  logic                    RESET,
  input  logic                    ENABLE,
  input  logic [1:0]              freq,
  input  logic                    DEMOD_ON,
  input  logic                    RETRANSMIT,
  input  logic [ADC_W-1:0]        ADC_DATA,
  input  logic                    OUT_READY,
  output logic                    OUT_VALID,
  output logic signed [ACC_W-1:0] I_SUM,
  output logic signed [ACC_W-1:0] Q_SUM,
  output logic [CNT_W-1:0]        SAMPLE_COUNT,
  output logic                    SAT,
  output logic                    OVERRUN
);

  state_e             state_q;
  logic               demod_on_q;
  logic [1:0]         div_d, div_q;
  logic [2:0]         phase_d, phase_q;
  logic               samp_vld_q;
  logic [ADC_W-1:0]   samp_q;
  logic [2:0]         samp_ph_q;
  logic [CNT_W-1:0]   cnt_d, cnt_q;
  logic               out_valid_q, sat_q, overrun_q;
  logic [ACC_W-1:0]   i_sum_q, q_sum_q;
  logic [CNT_W-1:0]   cnt_out_q;

  logic               rise, strobe, start, take, acc_en, latch;
  logic [1:0]         div_eff;
  logic [2:0]         phase_eff;
  logic signed [ACC_W-1:0] acc_i, acc_q;
  logic               clip_i, clip_q;

  // Window edge, sample strobe, phase tracking and sample count.
  always_comb begin
    rise      = DEMOD_ON & ~demod_on_q;
    div_eff   = rise ? 2'd0 : div_q;
    phase_eff = rise ? 3'd0 : phase_q;
    strobe    = DEMOD_ON & (div_eff == 2'd0);
    start     = ENABLE & rise & (state_q == ST_IDLE);
    take      = ENABLE & strobe & (start | (state_q == ST_ACCUM));
    acc_en    = ENABLE & samp_vld_q;
    latch     = ENABLE & RETRANSMIT & (state_q == ST_DONE);
    div_d     = (div_eff == div_last(freq)) ? 2'd0 : (div_eff + 2'd1);
    phase_d   = strobe ? (phase_eff + 3'd1) : phase_eff;
    if (start) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (acc_en && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Sampling pipeline stage and timing registers.
  always_ff @(posedge coreClock or posedge RESET) begin
    if (RESET) begin
      demod_on_q <= 1'b0;
      div_q      <= 2'd0;
      phase_q    <= 3'd0;
      samp_vld_q <= 1'b0;
      samp_q     <= {ADC_W{1'b0}};
      samp_ph_q  <= 3'd0;
      cnt_q      <= {CNT_W{1'b0}};
    end else begin
      demod_on_q <= DEMOD_ON;
      div_q      <= div_d;
      phase_q    <= phase_d;
      samp_vld_q <= take;
      samp_q     <= take ? ADC_DATA : samp_q;
      samp_ph_q  <= take ? phase_eff : samp_ph_q;
      cnt_q      <= cnt_d;
    end
  end

  quadrature_demodulator_channel #(.ADC_W(ADC_W), .ACC_W(ACC_W)) u_chan_i (
    .clk_i    (coreClock),
    .rst_i    (RESET),
    .clr_i    (start),
    .en_i     (acc_en),
    .sub_i    (iref_neg(samp_ph_q)),
    .sample_i (samp_q),
    .acc_o    (acc_i),
    .clip_o   (clip_i)
  );

  quadrature_demodulator_channel #(.ADC_W(ADC_W), .ACC_W(ACC_W)) u_chan_q (
    .clk_i    (coreClock),
    .rst_i    (RESET),
    .clr_i    (start),
    .en_i     (acc_en),
    .sub_i    (qref_neg(samp_ph_q)),
    .sample_i (samp_q),
    .acc_o    (acc_q),
    .clip_o   (clip_q)
  );

  // Pulse FSM with the result/handshake registers it drives.
  always_ff @(posedge coreClock or posedge RESET) begin
    if (RESET) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      i_sum_q     <= {ACC_W{1'b0}};
      q_sum_q     <= {ACC_W{1'b0}};
      cnt_out_q   <= {CNT_W{1'b0}};
      sat_q       <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      // A consumer taking the old result frees the slot for a same-cycle latch.
      if (latch) begin
        if (!out_valid_q || OUT_READY) begin
          out_valid_q <= 1'b1;
          i_sum_q     <= acc_i;
          q_sum_q     <= acc_q;
          cnt_out_q   <= cnt_q;
          sat_q       <= clip_i | clip_q;
        end else begin
          overrun_q   <= 1'b1;
        end
      end else if (out_valid_q && OUT_READY) begin
        out_valid_q <= 1'b0;
      end else begin
        out_valid_q <= out_valid_q;
      end

      if (!ENABLE) begin
        state_q <= ST_IDLE;
      end else begin
        case (state_q)
          ST_IDLE:  state_q <= rise ? ST_ACCUM : ST_IDLE;
          ST_ACCUM: state_q <= DEMOD_ON ? ST_ACCUM : ST_DONE;
          ST_DONE:  state_q <= RETRANSMIT ? ST_IDLE : ST_DONE;
          default:  state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign OUT_VALID    = out_valid_q;
  assign I_SUM        = i_sum_q;
  assign Q_SUM        = q_sum_q;
  assign SAMPLE_COUNT = cnt_out_q;
  assign SAT          = sat_q;
  assign OVERRUN      = overrun_q;

endmodule
